gcd_unit: RTL and testbench
===========================

Name: gcd_unit

Overview:
- Parametrised, self-contained GCD engine (successor to the split controller/datapath GCD).
- Both operands are loaded in parallel on a start handshake. The block iterates in either subtraction (Euclid) or binary (Stein) mode, selected at elaboration.
- On completion it returns the result with a one-cycle done pulse and an iteration count.
- Sits as a leaf accelerator beside other arithmetic examples; driven by a simple start/busy/done master.

Parameters:
- WIDTH, 16, operand and result width in bits.
- MODE, 0, algorithm: 0 = subtractive Euclid, 1 = binary Stein (shift/subtract).
- CNT_W, 16, width of iteration counter; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A, captured on accepted start.
- b_in  input  WIDTH  operand B, captured on accepted start.
- busy  output  1  high from the cycle after accept until done cycle, inclusive.
- done  output  1  single-cycle completion pulse.
- gcd_out  output  WIDTH  result; valid with done, held until next accept.
- zero_err  output  1  set with done when both operands were 0; held with gcd_out.
- iter_cnt  output  CNT_W  number of CALC cycles used; held with gcd_out.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, gcd_out=0, zero_err=0, iter_cnt=0; internal A, B, shift count k = 0. Reset mid-computation aborts immediately with no done pulse.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at an edge (accept):
  - Capture a_in/b_in.
  - Clear iter_cnt, zero_err, k.
  - Next state is CALC, except if a_in==0 or b_in==0, in which case next state is DONE with result = a_in|b_in and zero_err = (a_in==0 && b_in==0).
- start is ignored while busy; it is not queued.
- CALC, one step per cycle; iter_cnt increments every CALC cycle, saturating.
  - MODE 0:
    - A==B → DONE, result=A.
    - A>B → A=A-B.
    - else B=B-A.
  - MODE 1, priority order:
    - A==B → DONE, result=A<<k.
    - both even → A>>=1, B>>=1, k++.
    - A even → A>>=1.
    - B even → B>>=1.
    - else larger = larger - smaller.
  - k width is clog2(WIDTH)+1; A<<k is truncated to WIDTH. This cannot overflow for valid inputs.
- DONE: done=1 and busy=1 for exactly one cycle; gcd_out, zero_err and iter_cnt register the result. Next state is IDLE. start is not accepted in DONE.
- Latency:
  - Accept edge T0 → CALC cycles T1..Tn (n = iter_cnt) → done at T(n+1).
  - Zero-operand case: done at T1, iter_cnt=0.
- Back-to-back: start high in the cycle after done (IDLE) is accepted normally. Minimum issue interval = n+2 cycles.
- All arithmetic is unsigned. Subtraction never underflows because the larger operand is always the minuend.

Test Plan:
- MODE 0, a=6, b=4, start one cycle → CALC states (6,4),(2,4),(2,2); done at T4; gcd_out=2, iter_cnt=3, zero_err=0; busy high T1..T4.
- MODE 0, a=48, b=18 → sequence 48/18, 30/18, 12/18, 12/6, 6/6; gcd_out=6, iter_cnt=5. Then start again in the IDLE cycle with a=17, b=5 → gcd_out=1; previous result held until the new done.
- MODE 1, a=6, b=4 → (6,4) k0, (3,2) k1, (3,1), (2,1), (1,1); gcd_out=2, iter_cnt=5.
- Zero handling:
  - a=0, b=9 → done at T1, gcd_out=9, iter_cnt=0, zero_err=0.
  - a=0, b=0 → gcd_out=0, zero_err=1.
- Busy/abort:
  - start held high, plus new operands, during CALC → ignored; result matches the first operands.
  - rst_n pulsed low mid-CALC (asynchronously, between edges) → outputs 0 immediately, no done pulse; a fresh start afterwards completes correctly.
- WIDTH=8, MODE 0, a=255, b=1 → gcd_out=1, iter_cnt=255. With CNT_W=4 → iter_cnt saturates at 15; result is still correct.

Source files
------------

// File: rtl/gcd_unit.sv
// gcd_unit: iterative GCD engine, subtractive Euclid or binary Stein selected by MODE
module gcd_unit #(
    parameter int WIDTH = 16,
    parameter int MODE  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic             zero_err,
    output logic [CNT_W-1:0] iter_cnt
);
    localparam int KW = $clog2(WIDTH) + 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zerr_q, zerr_d;

    // next-state: operand capture on accept, one reduction step per CALC cycle
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        gcd_d   = gcd_q;
        zerr_d  = zerr_q;
        case (state_q)
            S_IDLE: if (start) begin
                a_d    = a_in;
                b_d    = b_in;
                k_d    = '0;
                cnt_d  = '0;
                zerr_d = 1'b0;
                if (a_in == '0 || b_in == '0) begin
                    state_d = S_DONE;
                    gcd_d   = a_in | b_in;
                    zerr_d  = (a_in == '0) && (b_in == '0);
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                if (a_q == b_q) begin
                    state_d = S_DONE;
                    gcd_d   = (MODE == 0) ? a_q : a_q << k_q;
                end else if (MODE == 0) begin
                    a_d = (a_q > b_q) ? a_q - b_q : a_q;
                    b_d = (a_q > b_q) ? b_q : b_q - a_q;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + 1'b1;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else begin
                    a_d = (a_q > b_q) ? a_q - b_q : a_q;
                    b_d = (a_q > b_q) ? b_q : b_q - a_q;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers; reset aborts any computation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            zerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            zerr_q  <= zerr_d;
        end
    end

    assign busy     = state_q != S_IDLE;
    assign done     = state_q == S_DONE;
    assign gcd_out  = gcd_q;
    assign zero_err = zerr_q;
    assign iter_cnt = cnt_q;
endmodule

// File: tb/tb_gcd_unit.sv
// tb_gcd_unit: vector table plus corner sequences over four gcd_unit configurations
module tb_gcd_unit;
    typedef struct {
        int          s;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] g;
        logic        z;
        int          n;
        int          lat;
    } vec_t;
    typedef struct {
        logic [15:0] g;
        logic        z;
        int          n;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  st = '0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic [3:0]  bz, dn, ze;
    logic [15:0] g0, g1, c0, c1, c2;
    logic [7:0]  g2, g3;
    logic [3:0]  c3;
    logic [15:0] gv [4];
    logic [15:0] cv [4];
    exp_t        sb [$];
    vec_t        vt [14];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    gcd_unit #(.WIDTH(16), .MODE(0), .CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .start(st[0]), .a_in(a_in), .b_in(b_in),
        .busy(bz[0]), .done(dn[0]), .gcd_out(g0), .zero_err(ze[0]), .iter_cnt(c0));
    gcd_unit #(.WIDTH(16), .MODE(1), .CNT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .start(st[1]), .a_in(a_in), .b_in(b_in),
        .busy(bz[1]), .done(dn[1]), .gcd_out(g1), .zero_err(ze[1]), .iter_cnt(c1));
    gcd_unit #(.WIDTH(8), .MODE(0), .CNT_W(16)) u2 (.clk(clk), .rst_n(rst_n), .start(st[2]), .a_in(a_in[7:0]), .b_in(b_in[7:0]),
        .busy(bz[2]), .done(dn[2]), .gcd_out(g2), .zero_err(ze[2]), .iter_cnt(c2));
    gcd_unit #(.WIDTH(8), .MODE(0), .CNT_W(4)) u3 (.clk(clk), .rst_n(rst_n), .start(st[3]), .a_in(a_in[7:0]), .b_in(b_in[7:0]),
        .busy(bz[3]), .done(dn[3]), .gcd_out(g3), .zero_err(ze[3]), .iter_cnt(c3));

    assign gv[0] = g0;
    assign gv[1] = g1;
    assign gv[2] = {8'd0, g2};
    assign gv[3] = {8'd0, g3};
    assign cv[0] = c0;
    assign cv[1] = c1;
    assign cv[2] = c2;
    assign cv[3] = {12'd0, c3};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // called at a negedge; start is sampled by the following posedge
    task automatic issue(input vec_t v);
        exp_t e;
        e = '{v.g, v.z, v.n, v.lat};
        sb.push_back(e);
        a_in = v.a;
        b_in = v.b;
        st[v.s] = 1'b1;
        @(negedge clk);
        st[v.s] = 1'b0;
    endtask

    // entered at the negedge of T1; returns at the negedge of the IDLE cycle after done
    task automatic finish_one(input int s);
        int          cyc;
        logic        bok, hok;
        logic [15:0] gp;
        exp_t        e;
        cyc = 1;
        bok = 1'b1;
        hok = 1'b1;
        gp  = gv[s];
        while (!dn[s] && cyc < 2000) begin
            bok &= bz[s];
            hok &= (gv[s] == gp);
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", {31'd0, dn[s]}, 1);
        e = sb.pop_front();
        chk("gcd_out", gv[s], e.g);
        chk("zero_err", ze[s], e.z);
        chk("iter_cnt", cv[s], e.n);
        chk("latency", cyc, e.lat);
        chk("busy_span", bok & bz[s], 1);
        chk("result_held", hok, 1);
        @(negedge clk);
        chk("done_pulse_end", {dn[s], bz[s]}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic nd;
        vt[0]  = '{0, 16'd6,   16'd4,  16'd2, 1'b0, 3,   4};
        vt[1]  = '{0, 16'd48,  16'd18, 16'd6, 1'b0, 5,   6};
        vt[2]  = '{0, 16'd17,  16'd5,  16'd1, 1'b0, 7,   8};
        vt[3]  = '{0, 16'd0,   16'd9,  16'd9, 1'b0, 0,   1};
        vt[4]  = '{0, 16'd0,   16'd0,  16'd0, 1'b1, 0,   1};
        vt[5]  = '{0, 16'd7,   16'd7,  16'd7, 1'b0, 1,   2};
        vt[6]  = '{0, 16'd9,   16'd0,  16'd9, 1'b0, 0,   1};
        vt[7]  = '{1, 16'd6,   16'd4,  16'd2, 1'b0, 5,   6};
        vt[8]  = '{1, 16'd12,  16'd18, 16'd6, 1'b0, 5,   6};
        vt[9]  = '{1, 16'd48,  16'd18, 16'd6, 1'b0, 7,   8};
        vt[10] = '{1, 16'd0,   16'd0,  16'd0, 1'b1, 0,   1};
        vt[11] = '{1, 16'd8,   16'd8,  16'd8, 1'b0, 1,   2};
        vt[12] = '{2, 16'd255, 16'd1,  16'd1, 1'b0, 255, 256};
        vt[13] = '{3, 16'd255, 16'd1,  16'd1, 1'b0, 15,  256};
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            chk("reset_out", gv[s] | cv[s], 0);
            chk("reset_flags", {bz[s], dn[s], ze[s]}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            issue(vt[i]);
            finish_one(vt[i].s);
        end
        // start held with fresh operands during CALC must be ignored
        issue(vt[1]);
        a_in = 16'd5;
        b_in = 16'd5;
        st[0] = 1'b1;
        fork
            begin
                repeat (3) @(negedge clk);
                st[0] = 1'b0;
            end
        join_none
        finish_one(0);
        // asynchronous reset mid-CALC: immediate clear, no done pulse
        issue(vt[2]);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out", gv[0] | cv[0], 0);
        chk("abort_flags", {bz[0], dn[0], ze[0]}, 0);
        void'(sb.pop_back());
        nd = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            nd &= ~dn[0];
            @(negedge clk);
        end
        chk("abort_no_done", {nd, bz[0]}, 2);
        issue(vt[0]);
        finish_one(0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
